// File: rtl/ase_umsg_ctrl.sv
// UMsg hint/data delivery engine: NUM_UMSG per-slot delay FSMs merged by a
// round-robin arbiter onto one registered valid/ready beat output.
module ase_umsg_ctrl #(
    parameter int NUM_UMSG    = 8,
    parameter int TIMER_WIDTH = 8,
    parameter int DATA_WIDTH  = 512,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(NUM_UMSG)-1:0] cmd_id,
    input  logic [DATA_WIDTH-1:0]       cmd_data,
    input  logic [NUM_UMSG-1:0]         hint_mask,
    input  logic [TIMER_WIDTH-1:0]      hint_delay,
    input  logic [TIMER_WIDTH-1:0]      data_delay,
    output logic                        umsg_valid,
    input  logic                        umsg_ready,
    output logic [27:0]                 umsg_hdr,
    output logic [DATA_WIDTH-1:0]       umsg_data,
    output logic [NUM_UMSG-1:0]         slot_busy,
    output logic [CNT_WIDTH-1:0]        coalesce_cnt
);
    localparam int ID_W = $clog2(NUM_UMSG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HINT_WAIT,
        S_SEND_HINT,
        S_DATA_WAIT,
        S_SEND_DATA
    } slot_state_e;

    slot_state_e            state_q [NUM_UMSG];
    slot_state_e            state_d [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_q [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer_d [NUM_UMSG];
    logic [DATA_WIDTH-1:0]  buf_q   [NUM_UMSG];
    logic [DATA_WIDTH-1:0]  buf_d   [NUM_UMSG];

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  umsg_valid_q, umsg_valid_d;
    logic [27:0]           umsg_hdr_q, umsg_hdr_d;
    logic [DATA_WIDTH-1:0] umsg_data_q, umsg_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [NUM_UMSG-1:0] req;
    logic [NUM_UMSG-1:0] acc;
    logic [ID_W:0]       arb_sum;
    logic                out_free;
    logic                grant_vld;
    logic                grant;
    logic                grant_hint;
    logic [ID_W-1:0]     grant_idx;
    logic                coalesce;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + CNT_WIDTH'(1);
    endfunction

    function automatic logic [27:0] make_hdr(input logic is_hint, input logic [ID_W-1:0] id);
        logic [27:0] h;
        h        = '0;
        h[19:16] = 4'h6;
        h[15]    = is_hint;
        h[5:0]   = 6'(id);
        return h;
    endfunction

    // Ready depends only on the addressed slot's state, never on cmd_valid.
    always_comb begin
        cmd_ready = 1'b1;
        for (int i = 0; i < NUM_UMSG; i++) begin
            if (cmd_id == ID_W'(i)) begin
                cmd_ready = (state_q[i] != S_SEND_DATA);
            end
        end
    end

    always_comb begin
        acc       = '0;
        req       = '0;
        slot_busy = '0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            acc[i]       = cmd_valid && cmd_ready && (cmd_id == ID_W'(i));
            req[i]       = (state_q[i] == S_SEND_HINT) || (state_q[i] == S_SEND_DATA);
            slot_busy[i] = (state_q[i] != S_IDLE);
        end
    end

    // First requester at or after the pointer, wrapping at NUM_UMSG.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_sum   = '0;
        for (int k = 0; k < NUM_UMSG; k++) begin
            arb_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (arb_sum >= (ID_W+1)'(NUM_UMSG)) begin
                arb_sum = arb_sum - (ID_W+1)'(NUM_UMSG);
            end
            if (!grant_vld && req[arb_sum[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = arb_sum[ID_W-1:0];
            end
        end
    end

    assign out_free   = !umsg_valid_q || umsg_ready;
    assign grant      = out_free && grant_vld;
    assign grant_hint = (state_q[grant_idx] == S_SEND_HINT);

    always_comb begin
        umsg_valid_d = umsg_valid_q;
        umsg_hdr_d   = umsg_hdr_q;
        umsg_data_d  = umsg_data_q;
        ptr_d        = ptr_q;
        if (out_free) begin
            umsg_valid_d = grant_vld;
            if (grant_vld) begin
                umsg_hdr_d  = make_hdr(grant_hint, grant_idx);
                umsg_data_d = grant_hint ? '0 : buf_q[grant_idx];
                ptr_d       = (grant_idx == ID_W'(NUM_UMSG-1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

    // Grant transitions use the pre-accept state; an accept to a busy slot
    // only refreshes the buffer, so both can apply in the same cycle.
    always_comb begin
        coalesce = 1'b0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            buf_d[i]   = buf_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (acc[i]) begin
                        if (hint_mask[i]) begin
                            state_d[i] = S_HINT_WAIT;
                            timer_d[i] = hint_delay;
                        end else begin
                            state_d[i] = S_DATA_WAIT;
                            timer_d[i] = data_delay;
                        end
                    end
                end
                S_HINT_WAIT: begin
                    if (timer_q[i] == '0) begin
                        state_d[i] = S_SEND_HINT;
                    end else begin
                        timer_d[i] = timer_q[i] - TIMER_WIDTH'(1);
                    end
                end
                S_SEND_HINT: begin
                    if (grant && (grant_idx == ID_W'(i))) begin
                        state_d[i] = S_DATA_WAIT;
                        timer_d[i] = data_delay;
                    end
                end
                S_DATA_WAIT: begin
                    if (timer_q[i] == '0) begin
                        state_d[i] = S_SEND_DATA;
                    end else begin
                        timer_d[i] = timer_q[i] - TIMER_WIDTH'(1);
                    end
                end
                S_SEND_DATA: begin
                    if (grant && (grant_idx == ID_W'(i))) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
            if (acc[i]) begin
                buf_d[i] = cmd_data;
                if (state_q[i] != S_IDLE) begin
                    coalesce = 1'b1;
                end
            end
        end
    end

    assign cnt_d = coalesce ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
            end
            ptr_q        <= '0;
            umsg_valid_q <= 1'b0;
            umsg_hdr_q   <= '0;
            umsg_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ptr_q        <= ptr_d;
            umsg_valid_q <= umsg_valid_d;
            umsg_hdr_q   <= umsg_hdr_d;
            umsg_data_q  <= umsg_data_d;
            cnt_q        <= cnt_d;
        end
    end

    // Payload buffers carry no control meaning and are left out of reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign umsg_valid   = umsg_valid_q;
    assign umsg_hdr     = umsg_hdr_q;
    assign umsg_data    = umsg_data_q;
    assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_ase_umsg_ctrl.sv
// Bench for ase_umsg_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a time-stamp based reference model.
module tb_ase_umsg_ctrl;
    localparam int N  = 8;
    localparam int TW = 8;
    localparam int DW = 512;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_id;
    logic [DW-1:0] cmd_data;
    logic [N-1:0]  hint_mask;
    logic [TW-1:0] hint_delay;
    logic [TW-1:0] data_delay;
    logic          umsg_valid;
    logic          umsg_ready;
    logic [27:0]   umsg_hdr;
    logic [DW-1:0] umsg_data;
    logic [N-1:0]  slot_busy;
    logic [CW-1:0] coalesce_cnt;

    ase_umsg_ctrl #(.NUM_UMSG(N), .TIMER_WIDTH(TW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_data(cmd_data), .hint_mask(hint_mask), .hint_delay(hint_delay),
        .data_delay(data_delay), .umsg_valid(umsg_valid), .umsg_ready(umsg_ready),
        .umsg_hdr(umsg_hdr), .umsg_data(umsg_data), .slot_busy(slot_busy),
        .coalesce_cnt(coalesce_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: per slot, what is pending (0 none, 1 hint, 2 data) and
    // the cycle from which that beat is requested.
    int            m_kind [N];
    int            m_due  [N];
    logic [DW-1:0] m_buf  [N];
    bit            m_valid;
    logic [27:0]   m_hdr;
    logic [DW-1:0] m_data;
    int            m_ptr;
    int            m_cnt;

    typedef struct {
        int            cyc;
        logic [27:0]   hdr;
        logic [DW-1:0] data;
    } beat_t;
    beat_t beats[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic bit m_req(input int i);
        return (m_kind[i] != 0) && (cyc >= m_due[i]);
    endfunction

    function automatic bit m_ready(input int id);
        return !((m_kind[id] == 2) && (cyc >= m_due[id]));
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = (m_kind[i] != 0);
        return b;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_kind[i] = 0;
            m_due[i]  = 0;
        end
        m_valid = 0;
        m_hdr   = '0;
        m_data  = '0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        int  g;
        int  id;
        int  pre_kind;
        bit  acc;
        if (rst) begin
            model_reset();
        end else begin
            id       = int'(cmd_id);
            acc      = cmd_valid && m_ready(id);
            pre_kind = m_kind[id];
            g        = -1;
            if (!m_valid || umsg_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && m_req((m_ptr + k) % N)) g = (m_ptr + k) % N;
                end
                if (g >= 0) begin
                    m_valid = 1;
                    m_hdr   = 28'h0060000 | 28'(g) | ((m_kind[g] == 1) ? 28'h0008000 : 28'h0);
                    m_data  = (m_kind[g] == 1) ? '0 : m_buf[g];
                    m_ptr   = (g + 1) % N;
                    if (m_kind[g] == 1) begin
                        m_kind[g] = 2;
                        m_due[g]  = cyc + 2 + int'(data_delay);
                    end else begin
                        m_kind[g] = 0;
                    end
                end else begin
                    m_valid = 0;
                end
            end
            if (acc) begin
                m_buf[id] = cmd_data;
                if (pre_kind == 0) begin
                    m_kind[id] = hint_mask[id] ? 1 : 2;
                    m_due[id]  = cyc + 2 + int'(hint_mask[id] ? hint_delay : data_delay);
                end else if (m_cnt < 65535) begin
                    m_cnt++;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        chk("umsg_valid", DW'(umsg_valid), DW'(m_valid));
        chk("umsg_hdr", DW'(umsg_hdr), DW'(m_hdr));
        chk("umsg_data", umsg_data, m_data);
        chk("cmd_ready", DW'(cmd_ready), DW'(m_ready(int'(cmd_id))));
        chk("slot_busy", DW'(slot_busy), DW'(m_busy()));
        chk("coalesce_cnt", DW'(coalesce_cnt), DW'(CW'(m_cnt)));
        if (umsg_valid && umsg_ready) beats.push_back('{cyc, umsg_hdr, umsg_data});
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input int id, input logic [DW-1:0] d, input bit hint, input int hd, input int dd);
        cmd_valid  = 1'b1;
        cmd_id     = 3'(id);
        cmd_data   = d;
        hint_mask  = hint ? (N'(1) << id) : '0;
        hint_delay = TW'(hd);
        data_delay = TW'(dd);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int            t;
        logic [DW-1:0] d0, d5, d7, d4, d6;
        rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_data = '0; hint_mask = '0;
        hint_delay = '0; data_delay = '0; umsg_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        tick();
        chk("rst_valid", DW'(umsg_valid), '0);
        chk("rst_busy", DW'(slot_busy), '0);
        chk("rst_hdr", DW'(umsg_hdr), '0);
        rst = 1'b0;

        // Plain data beat, no hint, D=4
        beats.delete();
        t = cyc;
        send(3, {64{8'hA5}}, 0, 0, 4);
        repeat (5) tick();
        chk("A_busy_before", DW'(slot_busy[3]), DW'(1'b1));
        tick();
        chk("A_busy_after", DW'(slot_busy[3]), '0);
        chk("A_valid", DW'(umsg_valid), DW'(1'b1));
        repeat (6) tick();
        chk("A_nbeats", DW'(beats.size()), DW'(1));
        if (beats.size() >= 1) begin
            chk("A_cyc", DW'(beats[0].cyc), DW'(t + 7));
            chk("A_hdr", DW'(beats[0].hdr), DW'(28'h0060003));
            chk("A_data", beats[0].data, {64{8'hA5}});
        end

        // Hint then data, H=2 D=3
        beats.delete();
        d0 = rand_data();
        t  = cyc;
        send(1, d0, 1, 2, 3);
        repeat (14) tick();
        chk("B_nbeats", DW'(beats.size()), DW'(2));
        if (beats.size() >= 2) begin
            chk("B_hint_cyc", DW'(beats[0].cyc), DW'(t + 5));
            chk("B_hint_hdr", DW'(beats[0].hdr), DW'(28'h0068001));
            chk("B_hint_data", beats[0].data, '0);
            chk("B_data_cyc", DW'(beats[1].cyc), DW'(t + 10));
            chk("B_data_hdr", DW'(beats[1].hdr), DW'(28'h0060001));
            chk("B_data_data", beats[1].data, d0);
        end

        // Coalesce into a slot already in DataWait
        beats.delete();
        t = cyc;
        send(2, rand_data(), 0, 0, 6);
        tick();
        send(2, DW'(32'h77), 0, 0, 6);
        chk("C_coalesce", DW'(coalesce_cnt), DW'(1));
        repeat (10) tick();
        chk("C_nbeats", DW'(beats.size()), DW'(1));
        if (beats.size() >= 1) begin
            chk("C_cyc", DW'(beats[0].cyc), DW'(t + 9));
            chk("C_data", beats[0].data, DW'(32'h77));
        end

        // Three slots reach SendData together: pointer 0, then pointer 6
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            beats.delete();
            d0 = rand_data(); d5 = rand_data(); d7 = rand_data();
            t  = cyc;
            send(0, d0, 0, 0, 6);
            send(5, d5, 0, 0, 5);
            send(7, d7, 0, 0, 4);
            repeat (12) tick();
            chk("D_nbeats", DW'(beats.size()), DW'(3));
            if (beats.size() >= 3) begin
                chk("D_cyc0", DW'(beats[0].cyc), DW'(t + 9));
                chk("D_cyc2", DW'(beats[2].cyc), DW'(t + 11));
                chk("D_id0", DW'(beats[0].hdr[5:0]), DW'(pass == 0 ? 0 : 7));
                chk("D_id1", DW'(beats[1].hdr[5:0]), DW'(pass == 0 ? 5 : 0));
                chk("D_id2", DW'(beats[2].hdr[5:0]), DW'(pass == 0 ? 7 : 5));
                chk("D_data1", beats[1].data, pass == 0 ? d5 : d0);
            end
            if (pass == 0) begin
                send(5, rand_data(), 0, 0, 0);
                repeat (5) tick();
            end
        end

        // Back-pressure: slot 4 beat held, slot 6 stuck in SendData
        beats.delete();
        umsg_ready = 1'b0;
        d4 = rand_data(); d6 = rand_data();
        send(4, d4, 0, 0, 1);
        send(6, d6, 0, 0, 1);
        repeat (2) tick();
        cmd_id = 3'd6;
        for (int i = 0; i < 10; i++) begin
            chk("E_valid", DW'(umsg_valid), DW'(1'b1));
            chk("E_hdr", DW'(umsg_hdr), DW'(28'h0060004));
            chk("E_data", umsg_data, d4);
            chk("E_ready6", DW'(cmd_ready), '0);
            tick();
        end
        umsg_ready = 1'b1;
        repeat (4) tick();
        chk("E_nbeats", DW'(beats.size()), DW'(2));
        if (beats.size() >= 2) begin
            chk("E_first", DW'(beats[0].hdr), DW'(28'h0060004));
            chk("E_second", DW'(beats[1].hdr), DW'(28'h0060006));
            chk("E_second_data", beats[1].data, d6);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cmd_valid  = ($urandom_range(0, 99) < 50);
            cmd_id     = 3'($urandom_range(0, N-1));
            cmd_data   = rand_data();
            hint_mask  = N'($urandom);
            hint_delay = TW'($urandom_range(0, 5));
            data_delay = TW'($urandom_range(0, 5));
            umsg_ready = ($urandom_range(0, 99) < 70);
            rst        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; cmd_valid = 1'b0;

        // Reset while four slots are busy and a beat is held
        do_reset();
        umsg_ready = 1'b0;
        send(0, rand_data(), 0, 0, 0);
        send(1, rand_data(), 0, 0, 20);
        send(2, rand_data(), 0, 0, 20);
        send(3, rand_data(), 0, 0, 20);
        send(3, rand_data(), 0, 0, 20);
        send(5, rand_data(), 0, 0, 20);
        chk("F_pre_valid", DW'(umsg_valid), DW'(1'b1));
        chk("F_pre_busy", DW'(slot_busy), DW'(8'b0010_1110));
        chk("F_pre_cnt", DW'(coalesce_cnt), DW'(1));
        do_reset();
        chk("F_valid", DW'(umsg_valid), '0);
        chk("F_busy", DW'(slot_busy), '0);
        chk("F_cnt", DW'(coalesce_cnt), '0);
        umsg_ready = 1'b1;
        beats.delete();
        repeat (30) tick();
        chk("F_nbeats", DW'(beats.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
